// File: rtl/i2c_reg_seq.sv
// Single-register I2C read/write sequencer driving a byte-level I2C master command port.
// Optional per-step watchdog enabled by defining I2C_REG_SEQ_TIMEOUT_EN.
module i2c_reg_seq #(
  parameter int ADDR_SZ     = 7,
  parameter int DATA_SZ     = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               I_START,
  input  logic [ADDR_SZ-1:0] I_DEV_ADDR,
  input  logic [DATA_SZ-1:0] I_REG_ADDR,
  input  logic               I_RW,
  input  logic [DATA_SZ-1:0] I_WDATA,
  output logic [DATA_SZ-1:0] O_RDATA,
  output logic               O_DONE,
  output logic               O_ERR,
  output logic               O_BUSY,
  output logic               O_M_EN,
  output logic [ADDR_SZ-1:0] O_M_ADDR,
  output logic               O_M_RW,
  output logic [DATA_SZ-1:0] O_M_DATA_WR,
  input  logic [DATA_SZ-1:0] I_M_DATA_RD,
  input  logic               I_M_ACK_FL,
  input  logic               I_M_BUSY
);

  // state | meaning
  // IDLE  | waiting for I_START
  // REG   | dev+W and register byte presented, waiting for the master to latch them
  // DATA  | write data byte presented
  // RADDR | dev+R presented (repeated START), read byte in flight
  // STOP  | EN low, waiting for the master to finish the last byte
  // DONE  | one-cycle result pulse
  typedef enum logic [2:0] {
    S_IDLE, S_REG, S_DATA, S_RADDR, S_STOP, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_busy_d;
  logic               r_m_en, w_m_en_nxt;
  logic [ADDR_SZ-1:0] r_m_addr, w_m_addr_nxt;
  logic               r_m_rw, w_m_rw_nxt;
  logic [DATA_SZ-1:0] r_m_data_wr, w_m_data_wr_nxt;
  logic [DATA_SZ-1:0] r_rdata, w_rdata_nxt;
  logic               r_err, w_err_nxt;
  logic               r_rw, w_rw_nxt;
  logic [DATA_SZ-1:0] r_wdata, w_wdata_nxt;
  logic               w_rise, w_fall, w_active, w_timeout;

  assign w_rise   = I_M_BUSY & ~r_busy_d;
  assign w_fall   = ~I_M_BUSY & r_busy_d;
  assign w_active = (r_state == S_REG) || (r_state == S_DATA) ||
                    (r_state == S_RADDR) || (r_state == S_STOP);

`ifdef I2C_REG_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = w_active && (r_cnt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_cnt <= '0;
    end else if ((w_state_nxt != r_state) || w_rise || w_fall) begin
      r_cnt <= '0;
    end else if (w_active) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_m_en_nxt      = r_m_en;
    w_m_addr_nxt    = r_m_addr;
    w_m_rw_nxt      = r_m_rw;
    w_m_data_wr_nxt = r_m_data_wr;
    w_rdata_nxt     = r_rdata;
    w_err_nxt       = r_err;
    w_rw_nxt        = r_rw;
    w_wdata_nxt     = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (I_START) begin
          w_rw_nxt        = I_RW;
          w_wdata_nxt     = I_WDATA;
          w_err_nxt       = 1'b0;
          w_m_en_nxt      = 1'b1;
          w_m_addr_nxt    = I_DEV_ADDR;
          w_m_rw_nxt      = 1'b0;
          w_m_data_wr_nxt = I_REG_ADDR;
          w_state_nxt     = S_REG;
        end
      end
      S_REG: begin
        if (w_rise) begin
          if (r_rw) begin
            w_m_rw_nxt  = 1'b1;
            w_state_nxt = S_RADDR;
          end else begin
            w_m_data_wr_nxt = r_wdata;
            w_state_nxt     = S_DATA;
          end
        end
      end
      S_DATA, S_RADDR: begin
        if (w_rise) begin
          w_m_en_nxt  = 1'b0;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        w_m_en_nxt = 1'b0;
        if (w_fall) begin
          if (r_rw && !r_err) w_rdata_nxt = I_M_DATA_RD;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort paths override whatever byte advance was decoded above.
    if (w_active && (w_timeout || I_M_ACK_FL)) begin
      w_m_en_nxt      = 1'b0;
      w_err_nxt       = 1'b1;
      w_m_rw_nxt      = r_m_rw;
      w_m_data_wr_nxt = r_m_data_wr;
      w_rdata_nxt     = r_rdata;
      if (w_timeout || !I_M_BUSY) w_state_nxt = S_DONE;
      else                        w_state_nxt = S_STOP;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_state     <= S_IDLE;
      r_busy_d    <= 1'b0;
      r_m_en      <= 1'b0;
      r_m_addr    <= '0;
      r_m_rw      <= 1'b0;
      r_m_data_wr <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_rw        <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy_d    <= I_M_BUSY;
      r_m_en      <= w_m_en_nxt;
      r_m_addr    <= w_m_addr_nxt;
      r_m_rw      <= w_m_rw_nxt;
      r_m_data_wr <= w_m_data_wr_nxt;
      r_rdata     <= w_rdata_nxt;
      r_err       <= w_err_nxt;
      r_rw        <= w_rw_nxt;
      r_wdata     <= w_wdata_nxt;
    end
  end

  assign O_BUSY      = (r_state != S_IDLE);
  assign O_DONE      = (r_state == S_DONE);
  assign O_ERR       = O_DONE & r_err;
  assign O_RDATA     = r_rdata;
  assign O_M_EN      = r_m_en;
  assign O_M_ADDR    = r_m_addr;
  assign O_M_RW      = r_m_rw;
  assign O_M_DATA_WR = r_m_data_wr;

endmodule
